mul_error_sweeper: RTL and testbench

- Sequential characterisation engine for the 8x8 partial-product multipliers.
- Upstream of the multipliers, it drives every (a,b) operand pair exhaustively, one pair per cycle.
- Downstream of them, it consumes the accurate product and the approximate product and accumulates error metrics: error count, sum of error distance, signed bias, and worst case with location.
- Sits beside the multiplier pair in the characterisation top, with a start/busy/done handshake to the controller.

---
 rtl/mul_sweep_pkg.sv | 28 ++
 rtl/error_metric_stage.sv | 63 ++++++
 rtl/mul_error_sweeper.sv | 206 ++++++++++++++++++++
 tb/tb_mul_error_sweeper.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_sweep_pkg.sv
// Shared definitions for the multiplier error sweeper.
// Holds the default operand width, the widths derived from it, the number
// of operand pairs in one exhaustive sweep and the controller state encoding.
package mul_sweep_pkg;

    // Default operand width and derived widths.
    localparam int W_DEF = 8;
    localparam int PW    = 2 * W_DEF;     // product / index width
    localparam int CW    = 2 * W_DEF + 1; // signed difference / error count width
    localparam int SW    = 4 * W_DEF;     // sum of error distance width

    // Number of (a,b) pairs covered by one sweep at the default width.
    localparam int unsigned N = 32'd1 << PW;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // True while a sweep is in flight (operands issuing or results draining).
    function automatic logic is_active(input state_e s);
        return (s == ST_SWEEP) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/error_metric_stage.sv
// Registered error-metric stage.
// Compares the accurate and approximate products of one operand pair and
// registers the absolute error distance, the signed difference (acc - apx),
// the mismatch flag and the (a,b) tag that identifies the pair.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   vld, a, b      valid flag and operand tag of the incoming pair
//   acc, apx       accurate / approximate products for that pair
//   m_vld..m_ne    registered valid, tag, |acc-apx|, acc-apx, acc!=apx
module error_metric_stage #(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vld,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [2*W-1:0]  acc,
    input  logic [2*W-1:0]  apx,
    output logic            m_vld,
    output logic [W-1:0]    m_a,
    output logic [W-1:0]    m_b,
    output logic [2*W-1:0]  m_ed,
    output logic [2*W:0]    m_diff,
    output logic            m_ne
);

    logic [2*W-1:0] ed_s;
    logic [2*W:0]   diff_s;
    logic           ne_s;

    // Error metrics of the current pair; the distance is taken from the
    // larger operand so it never needs the extra sign bit.
    always_comb begin
        diff_s = {1'b0, acc} - {1'b0, apx};
        ne_s   = (acc != apx);
        if (acc >= apx) begin
            ed_s = acc - apx;
        end else begin
            ed_s = apx - acc;
        end
    end

    // Metric register with tag pass-through.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_vld  <= 1'b0;
            m_a    <= {W{1'b0}};
            m_b    <= {W{1'b0}};
            m_ed   <= {(2*W){1'b0}};
            m_diff <= {(2*W+1){1'b0}};
            m_ne   <= 1'b0;
        end else begin
            m_vld  <= vld;
            m_a    <= a;
            m_b    <= b;
            m_ed   <= ed_s;
            m_diff <= diff_s;
            m_ne   <= ne_s;
        end
    end

endmodule

// File: rtl/mul_error_sweeper.sv
// Exhaustive error characterisation engine for a pair of WxW multipliers.
// Issues every (a,b) pair once (a-major, b inner, one pair per cycle),
// captures the accurate and approximate products MUL_LAT cycles later and
// accumulates error count, sum of error distance, signed error sum and the
// first pair reaching the largest error distance.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                sweep request, honoured only in IDLE or DONE
//   a_out, b_out         registered operands to both multipliers
//   prod_acc, prod_apx   products returned by the multipliers
//   busy, done           handshake: busy while sweeping/draining, done level
//   err_count..max_b     live metrics, final once done is high
module mul_error_sweeper
    import mul_sweep_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int MUL_LAT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [W-1:0]    a_out,
    output logic [W-1:0]    b_out,
    input  logic [2*W-1:0]  prod_acc,
    input  logic [2*W-1:0]  prod_apx,
    output logic            busy,
    output logic            done,
    output logic [2*W:0]    err_count,
    output logic [4*W-1:0]  sum_ed,
    output logic [4*W:0]    sum_err,
    output logic [2*W-1:0]  max_ed,
    output logic [W-1:0]    max_a,
    output logic [W-1:0]    max_b
);

    localparam int IW = 2 * W; // index / product width

    state_e          state_r;
    state_e          state_s;
    logic            accept_s;
    logic            last_issue_s;
    logic            last_accum_s;

    logic [IW-1:0]   k_r;
    logic            iss_vld_r;

    logic            dl_vld_s;
    logic [W-1:0]    dl_a_s;
    logic [W-1:0]    dl_b_s;

    logic            m_vld_s;
    logic [W-1:0]    m_a_s;
    logic [W-1:0]    m_b_s;
    logic [IW-1:0]   m_ed_s;
    logic [IW:0]     m_diff_s;
    logic            m_ne_s;

    // Final index reached; the pair with all-ones operands is always the last.
    assign last_issue_s = (k_r == {IW{1'b1}});
    assign last_accum_s = m_vld_s && (m_a_s == {W{1'b1}}) && (m_b_s == {W{1'b1}});

    // Next-state logic and start acceptance.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s  = ST_SWEEP;
                    accept_s = 1'b1;
                end else begin
                    state_s  = state_r;
                    accept_s = 1'b0;
                end
            end
            ST_SWEEP: begin
                if (last_issue_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_SWEEP;
                end
            end
            ST_DRAIN: begin
                if (last_accum_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                accept_s = 1'b0;
            end
        endcase
    end

    // State register plus registered handshake outputs derived from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_s;
            busy    <= is_active(state_s);
            done    <= (state_s == ST_DONE);
        end
    end

    // Index counter and operand issue; operands hold their last value outside SWEEP.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_r       <= {IW{1'b0}};
            iss_vld_r <= 1'b0;
            a_out     <= {W{1'b0}};
            b_out     <= {W{1'b0}};
        end else if (accept_s) begin
            k_r       <= {IW{1'b0}};
            iss_vld_r <= 1'b0;
        end else if (state_r == ST_SWEEP) begin
            k_r       <= k_r + {{(IW-1){1'b0}}, 1'b1};
            iss_vld_r <= 1'b1;
            a_out     <= k_r[IW-1:W];
            b_out     <= k_r[W-1:0];
        end else begin
            iss_vld_r <= 1'b0;
        end
    end

    // Valid/tag delay line matching the multiplier pipeline depth.
    generate
        if (MUL_LAT == 0) begin : g_no_lat
            assign dl_vld_s = iss_vld_r;
            assign dl_a_s   = a_out;
            assign dl_b_s   = b_out;
        end else begin : g_lat
            logic [MUL_LAT-1:0] vld_pipe_r;
            logic [W-1:0]       a_pipe_r [MUL_LAT];
            logic [W-1:0]       b_pipe_r [MUL_LAT];

            // Shift register; stage 0 takes the pair issued this cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_pipe_r <= {MUL_LAT{1'b0}};
                    for (int i = 0; i < MUL_LAT; i++) begin
                        a_pipe_r[i] <= {W{1'b0}};
                        b_pipe_r[i] <= {W{1'b0}};
                    end
                end else begin
                    vld_pipe_r[0] <= iss_vld_r;
                    a_pipe_r[0]   <= a_out;
                    b_pipe_r[0]   <= b_out;
                    for (int i = 1; i < MUL_LAT; i++) begin
                        vld_pipe_r[i] <= vld_pipe_r[i-1];
                        a_pipe_r[i]   <= a_pipe_r[i-1];
                        b_pipe_r[i]   <= b_pipe_r[i-1];
                    end
                end
            end

            assign dl_vld_s = vld_pipe_r[MUL_LAT-1];
            assign dl_a_s   = a_pipe_r[MUL_LAT-1];
            assign dl_b_s   = b_pipe_r[MUL_LAT-1];
        end
    endgenerate

    error_metric_stage #(
        .W(W)
    ) u_metric (
        .clk    (clk),
        .rst    (rst),
        .vld    (dl_vld_s),
        .a      (dl_a_s),
        .b      (dl_b_s),
        .acc    (prod_acc),
        .apx    (prod_apx),
        .m_vld  (m_vld_s),
        .m_a    (m_a_s),
        .m_b    (m_b_s),
        .m_ed   (m_ed_s),
        .m_diff (m_diff_s),
        .m_ne   (m_ne_s)
    );

    // Accumulators; cleared on start acceptance, strict '>' keeps the earliest worst pair.
    always_ff @(posedge clk) begin
        if (rst || accept_s) begin
            err_count <= {(IW+1){1'b0}};
            sum_ed    <= {(2*IW){1'b0}};
            sum_err   <= {(2*IW+1){1'b0}};
            max_ed    <= {IW{1'b0}};
            max_a     <= {W{1'b0}};
            max_b     <= {W{1'b0}};
        end else if (m_vld_s) begin
            err_count <= err_count + {{IW{1'b0}}, m_ne_s};
            sum_ed    <= sum_ed + {{IW{1'b0}}, m_ed_s};
            sum_err   <= sum_err + {{IW{m_diff_s[IW]}}, m_diff_s};
            if (m_ed_s > max_ed) begin
                max_ed <= m_ed_s;
                max_a  <= m_a_s;
                max_b  <= m_b_s;
            end
        end
    end

endmodule

// File: tb/tb_mul_error_sweeper.sv
// Bench for mul_error_sweeper at W=4 (256 pairs per sweep), one instance
// with combinational multipliers and one with a two-cycle multiplier pipeline.
module tb_mul_error_sweeper;

    localparam int W    = 4;
    localparam int PW   = 2 * W;
    localparam int N    = 1 << PW;
    localparam int MAXV = (1 << W) - 1;

    typedef struct {
        longint cnt;
        longint sed;
        longint serr;
        longint maxed;
        int     ma;
        int     mb;
    } met_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            start0, start2;
    logic [W-1:0]    a0, b0, a2, b2;
    logic [PW-1:0]   acc0, apx0;
    logic [PW-1:0]   acc2_d1, apx2_d1, acc2_d2, apx2_d2;
    logic            busy0, done0, busy2, done2;
    logic [PW:0]     errc0, errc2;
    logic [2*PW-1:0] sed0, sed2;
    logic [2*PW:0]   serr0, serr2;
    logic [PW-1:0]   mx0, mx2;
    logic [W-1:0]    ma0, mb0, ma2, mb2;

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;
    int     mode_a [2];
    bit     trk    [2];
    bit     hold   [2];
    longint e0     [2];
    int     m_done [2];
    met_t   met    [2];

    mul_error_sweeper #(.W(W), .MUL_LAT(0)) u_l0 (
        .clk(clk), .rst(rst), .start(start0), .a_out(a0), .b_out(b0),
        .prod_acc(acc0), .prod_apx(apx0), .busy(busy0), .done(done0),
        .err_count(errc0), .sum_ed(sed0), .sum_err(serr0),
        .max_ed(mx0), .max_a(ma0), .max_b(mb0));

    mul_error_sweeper #(.W(W), .MUL_LAT(2)) u_l2 (
        .clk(clk), .rst(rst), .start(start2), .a_out(a2), .b_out(b2),
        .prod_acc(acc2_d2), .prod_apx(apx2_d2), .busy(busy2), .done(done2),
        .err_count(errc2), .sum_ed(sed2), .sum_err(serr2),
        .max_ed(mx2), .max_a(ma2), .max_b(mb2));

    // Approximate multiplier behaviour selected by mode.
    function automatic int apx_of(input int mode, input int a, input int b);
        int acc;
        int v;
        acc = a * b;
        case (mode)
            0: v = acc;
            1: v = acc & ~1;
            2: v = (a == MAXV && b == MAXV) ? 0 : acc;
            3: v = acc + ((a * 3 + b) % 7) - 3;
            default: v = acc;
        endcase
        return v & ((1 << PW) - 1);
    endfunction

    function automatic met_t met_zero();
        met_t m;
        m.cnt = 0; m.sed = 0; m.serr = 0; m.maxed = 0; m.ma = 0; m.mb = 0;
        return m;
    endfunction

    // Fold pair number k of the sweep into running metrics.
    function automatic met_t add_pair(input met_t m_in, input int mode, input int k);
        met_t m;
        int a, b, d, ed;
        m  = m_in;
        a  = k >> W;
        b  = k % (1 << W);
        d  = a * b - apx_of(mode, a, b);
        ed = (d < 0) ? -d : d;
        if (d != 0) m.cnt++;
        m.sed  += ed;
        m.serr += d;
        if (ed > m.maxed) begin
            m.maxed = ed; m.ma = a; m.mb = b;
        end
        return m;
    endfunction

    function automatic met_t full_model(input int mode);
        met_t m;
        m = met_zero();
        for (int k = 0; k < N; k++) m = add_pair(m, mode, k);
        return m;
    endfunction

    // Multiplier models: combinational for u_l0, two-cycle pipeline for u_l2.
    always_comb begin
        acc0 = {{W{1'b0}}, a0} * {{W{1'b0}}, b0};
        apx0 = PW'(apx_of(mode_a[0], int'(a0), int'(b0)));
    end

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        acc2_d1 <= {{W{1'b0}}, a2} * {{W{1'b0}}, b2};
        apx2_d1 <= PW'(apx_of(mode_a[1], int'(a2), int'(b2)));
        acc2_d2 <= acc2_d1;
        apx2_d2 <= apx2_d1;
    end

    task automatic cmp(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle check of one instance against the sweep timeline and model.
    task automatic chk(input int d, input logic busy, input logic done,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [PW:0] errc, input logic [2*PW-1:0] sed,
                       input logic signed [2*PW:0] serr, input logic [PW-1:0] mx,
                       input logic [W-1:0] ma, input logic [W-1:0] mb);
        longint c;
        int     lat;
        longint target;
        longint idx;
        string  p;
        if (!trk[d]) return;
        lat = (d == 0) ? 0 : 2;
        p   = (d == 0) ? "L0" : "L2";
        c   = cyc - e0[d];
        if (hold[d] && c == N + lat + 3) begin
            hold[d]   = 1'b0;
            e0[d]     = cyc;
            c         = 0;
            met[d]    = met_zero();
            m_done[d] = 0;
        end
        target = c - 2 - lat;
        if (target < 0) target = 0;
        if (target > N) target = N;
        while (m_done[d] < target) begin
            met[d] = add_pair(met[d], mode_a[d], m_done[d]);
            m_done[d]++;
        end
        cmp({p, " busy"}, busy, (c < N + 2 + lat) ? 1 : 0);
        cmp({p, " done"}, done, (c < N + 2 + lat) ? 0 : 1);
        if (c >= 1) begin
            idx = (c - 1 < N - 1) ? c - 1 : N - 1;
            cmp({p, " a_out"}, a, idx >> W);
            cmp({p, " b_out"}, b, idx % (1 << W));
        end
        cmp({p, " err_count"}, errc, met[d].cnt);
        cmp({p, " sum_ed"}, sed, met[d].sed);
        cmp({p, " sum_err"}, longint'(serr), met[d].serr);
        cmp({p, " max_ed"}, mx, met[d].maxed);
        cmp({p, " max_a"}, ma, met[d].ma);
        cmp({p, " max_b"}, mb, met[d].mb);
    endtask

    always @(negedge clk) begin
        chk(0, busy0, done0, a0, b0, errc0, sed0, serr0, mx0, ma0, mb0);
        chk(1, busy2, done2, a2, b2, errc2, sed2, serr2, mx2, ma2, mb2);
    end

    task automatic chk_zero(input int d);
        logic signed [2*PW:0] s;
        if (d == 0) begin
            s = serr0;
            cmp("zero busy", busy0, 0);   cmp("zero done", done0, 0);
            cmp("zero a", a0, 0);         cmp("zero b", b0, 0);
            cmp("zero errc", errc0, 0);   cmp("zero sed", sed0, 0);
            cmp("zero serr", longint'(s), 0);
            cmp("zero max", mx0, 0);      cmp("zero ma", ma0, 0);
            cmp("zero mb", mb0, 0);
        end else begin
            s = serr2;
            cmp("zero2 busy", busy2, 0);  cmp("zero2 done", done2, 0);
            cmp("zero2 a", a2, 0);        cmp("zero2 b", b2, 0);
            cmp("zero2 errc", errc2, 0);  cmp("zero2 sed", sed2, 0);
            cmp("zero2 serr", longint'(s), 0);
            cmp("zero2 max", mx2, 0);     cmp("zero2 ma", ma2, 0);
            cmp("zero2 mb", mb2, 0);
        end
    endtask

    task automatic chk_final(input int d, input longint cnt, input longint sed,
                             input longint serr, input longint mx, input int ma,
                             input int mb);
        logic signed [2*PW:0] s;
        s = (d == 0) ? serr0 : serr2;
        cmp("final done", (d == 0) ? done0 : done2, 1);
        cmp("final err_count", (d == 0) ? errc0 : errc2, cnt);
        cmp("final sum_ed", (d == 0) ? sed0 : sed2, sed);
        cmp("final sum_err", longint'(s), serr);
        cmp("final max_ed", (d == 0) ? mx0 : mx2, mx);
        cmp("final max_a", (d == 0) ? ma0 : ma2, ma);
        cmp("final max_b", (d == 0) ? mb0 : mb2, mb);
    endtask

    // Raise start before an edge at which the instance is idle/done; that edge is E0.
    task automatic begin_sweep(input int d, input int mode);
        @(negedge clk);
        mode_a[d] = mode;
        if (d == 0) start0 = 1'b1; else start2 = 1'b1;
        @(posedge clk);
        #1;
        e0[d]     = cyc;
        met[d]    = met_zero();
        m_done[d] = 0;
        trk[d]    = 1'b1;
    endtask

    task automatic end_start(input int d);
        @(negedge clk);
        if (d == 0) start0 = 1'b0; else start2 = 1'b0;
    endtask

    // Bounded wait for done; reports the edge count after E0 at which it was seen.
    task automatic wait_done(input int d, input longint exp_edge);
        int n;
        n = 0;
        while (((d == 0) ? done0 : done2) !== 1'b1 && n < N + 50) begin
            @(negedge clk);
            n++;
        end
        cmp("done seen", (d == 0) ? done0 : done2, 1);
        cmp("done edge", cyc - e0[d], exp_edge);
    endtask

    initial begin
        met_t m;
        int   n;
        rst = 1'b1; start0 = 1'b0; start2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mode_a[i] = 0; trk[i] = 1'b0; hold[i] = 1'b0;
            e0[i] = 0; m_done[i] = 0; met[i] = met_zero();
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero(0);
        chk_zero(1);
        rst = 1'b0;

        // Model pinned against hand-computed totals for a 4x4 sweep.
        m = full_model(0);
        cmp("model0 cnt", m.cnt, 0);    cmp("model0 sed", m.sed, 0);
        cmp("model0 max", m.maxed, 0);  cmp("model0 ma", m.ma, 0);
        m = full_model(1);
        cmp("model1 cnt", m.cnt, 64);   cmp("model1 sed", m.sed, 64);
        cmp("model1 serr", m.serr, 64); cmp("model1 max", m.maxed, 1);
        cmp("model1 ma", m.ma, 1);      cmp("model1 mb", m.mb, 1);
        m = full_model(2);
        cmp("model2 cnt", m.cnt, 1);    cmp("model2 sed", m.sed, 225);
        cmp("model2 serr", m.serr, 225); cmp("model2 max", m.maxed, 225);
        cmp("model2 ma", m.ma, 15);     cmp("model2 mb", m.mb, 15);

        // Exact multiplier: no error at all.
        begin_sweep(0, 0); end_start(0); wait_done(0, N + 2);
        chk_final(0, 0, 0, 0, 0, 0, 0);
        // LSB forced to zero.
        begin_sweep(0, 1); end_start(0); wait_done(0, N + 2);
        chk_final(0, 64, 64, 64, 1, 1, 1);
        // Single wrong pair at the very last index.
        begin_sweep(0, 2); end_start(0); wait_done(0, N + 2);
        chk_final(0, 1, 225, 225, 225, 15, 15);
        // Mixed positive/negative errors with many ties.
        begin_sweep(0, 3); end_start(0); wait_done(0, N + 2);

        // Start pulses while busy (mid-sweep and in DRAIN) are ignored.
        begin_sweep(0, 1); end_start(0);
        repeat (49) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (N - 50) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0, N + 2);
        chk_final(0, 64, 64, 64, 1, 1, 1);

        // Reset mid-sweep aborts; a fresh sweep then matches the clean run.
        begin_sweep(0, 1); end_start(0);
        repeat (99) @(negedge clk);
        trk[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk_zero(0);
        rst = 1'b0;
        begin_sweep(0, 1); end_start(0); wait_done(0, N + 2);
        chk_final(0, 64, 64, 64, 1, 1, 1);

        // Two-cycle multiplier pipeline.
        begin_sweep(1, 1); end_start(1); wait_done(1, N + 4);
        chk_final(1, 64, 64, 64, 1, 1, 1);
        begin_sweep(1, 3); end_start(1); wait_done(1, N + 4);

        // Start held high through DONE: re-accepted on the first DONE cycle.
        begin_sweep(0, 1);
        hold[0] = 1'b1;
        wait_done(0, N + 2);
        n = 0;
        while (busy0 !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        cmp("hold restart busy", busy0, 1);
        cmp("hold restart edge", n, 1);
        cmp("hold restart done", done0, 0);
        cmp("hold restart errc", errc0, 0);
        start0 = 1'b0;
        wait_done(0, N + 2);
        chk_final(0, 64, 64, 64, 1, 1, 1);

        trk[0] = 1'b0;
        trk[1] = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
